bure_lsu: RTL

Load/store unit that sits directly downstream of the execute-stage ALU. The ALU computes the effective address (register plus immediate) for every load and store; this block consumes that address with the store data and access size, and drives a single-outstanding request/grant/response data-memory port. It also performs byte-lane alignment and sign/zero extension, and returns load results to writeback. Misaligned or illegal accesses are trapped before any memory request is issued.

---
 rtl/bure_lsu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bure_lsu.sv
// bure_lsu: load/store unit fed by the execute-stage ALU address path.
//
// Accepts one load or store at a time, checks it for illegal size codes and
// misalignment, and drives a single-outstanding request/grant/response
// data-memory port. Load data is lane-extracted and sign/zero-extended
// before being returned to writeback.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     access handshake from execute (ready == idle)
//   i_is_store, i_funct3  access kind and size code
//   i_addr, i_wdata, i_rd effective address, store data, load destination
//   o_mem_*, i_mem_*      data-memory request/grant/response port
//   o_wb_*                one-cycle load writeback
//   o_st_done             one-cycle store completion pulse
//   o_exc*                one-cycle fault pulse with cause and faulting address
module bure_lsu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_rd,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_wb_valid,
    output logic [4:0]            o_wb_rd,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_st_done,
    output logic                  o_exc,
    output logic [1:0]            o_exc_cause,
    output logic [DATA_WIDTH-1:0] o_exc_addr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;

    logic [1:0]            state;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;

    logic                  illegal;
    logic                  misaligned;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  in_req;

    assign o_ready = (state == S_IDLE);
    assign in_req  = (state == S_REQ);

    // Fault classification of the incoming access; illegal wins over
    // misaligned because it is checked first when picking the cause.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11 || (i_is_store && i_funct3[2]))
            illegal = 1'b1;
        if ((i_funct3 == 3'b001 || i_funct3 == 3'b101) && i_addr[0])
            misaligned = 1'b1;
        if (i_funct3 == 3'b010 && i_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end

    // Store lane placement from the captured access.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    // Memory port is driven only in REQ, so it reads all-zero otherwise.
    assign o_mem_req   = in_req;
    assign o_mem_addr  = in_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign o_mem_we    = in_req & is_store_q;
    assign o_mem_be    = in_req ? (is_store_q ? st_be : 4'b1111) : 4'b0000;
    assign o_mem_wdata = (in_req && is_store_q) ? st_wdata : '0;

    // Load lane extraction and extension.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   ld_byte = i_mem_rdata[7:0];
            2'b01:   ld_byte = i_mem_rdata[15:8];
            2'b10:   ld_byte = i_mem_rdata[23:16];
            default: ld_byte = i_mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 5'd0;
            o_wb_valid  <= 1'b0;
            o_wb_rd     <= 5'd0;
            o_wb_data   <= '0;
            o_st_done   <= 1'b0;
            o_exc       <= 1'b0;
            o_exc_cause <= 2'b00;
            o_exc_addr  <= '0;
        end else begin
            o_wb_valid <= 1'b0;
            o_st_done  <= 1'b0;
            o_exc      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        is_store_q <= i_is_store;
                        funct3_q   <= i_funct3;
                        addr_q     <= i_addr;
                        wdata_q    <= i_wdata;
                        rd_q       <= i_rd;
                        if (illegal || misaligned) begin
                            o_exc       <= 1'b1;
                            o_exc_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                            o_exc_addr  <= i_addr;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_gnt) begin
                        if (is_store_q) begin
                            o_st_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_RSP;
                        end
                    end
                end
                S_RSP: begin
                    if (i_mem_rvalid) begin
                        o_wb_valid <= 1'b1;
                        o_wb_rd    <= rd_q;
                        o_wb_data  <= ld_data;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
